// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// datapath select values and the instruction-class one-hot.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic load;
        logic store;
        logic rtype;
        logic itype;
        logic branch;
        logic jal;
    } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_decoder.sv
// Combinational opcode decoder: immediate format select and instruction class.
module instr_type_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode_i,
    output logic [1:0]   imm_src_o,
    output instr_class_t class_o
);

    always_comb begin
        imm_src_o = IMM_I;
        class_o   = '0;
        case (opcode_i)
            OP_LOAD: begin
                imm_src_o     = IMM_I;
                class_o.load  = 1'b1;
            end
            OP_STORE: begin
                imm_src_o     = IMM_S;
                class_o.store = 1'b1;
            end
            OP_RTYPE: begin
                class_o.rtype = 1'b1;
            end
            OP_ITYPE: begin
                imm_src_o     = IMM_I;
                class_o.itype = 1'b1;
            end
            OP_BRANCH: begin
                imm_src_o      = IMM_B;
                class_o.branch = 1'b1;
            end
            OP_JAL: begin
                imm_src_o   = IMM_J;
                class_o.jal = 1'b1;
            end
            default: begin
                imm_src_o = IMM_I;
                class_o   = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main multicycle RV32I control FSM: sequences the shared ALU, memory port and
// register-file write, stalls on mem_ready and counts retired instructions.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_valid,
    output logic             Adr_src,
    output logic             Mem_write,
    output logic             IR_write,
    output logic             PC_write,
    output logic             Reg_write,
    output logic [1:0]       Result_src,
    output logic [1:0]       ALU_src_A,
    output logic [1:0]       ALU_src_B,
    output logic [1:0]       ALU_opcode,
    output logic [1:0]       Imm_src,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    instr_class_t cls;
    logic [1:0]   imm_src;

    logic       mv, adr, mw, irw, rw, ill, pc_update, branch, retire;
    logic [1:0] res, src_a, src_b, alu_op;

    instr_type_decoder u_dec (
        .opcode_i  (opcode),
        .imm_src_o (imm_src),
        .class_o   (cls)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mv        = 1'b0;
        adr       = 1'b0;
        mw        = 1'b0;
        irw       = 1'b0;
        rw        = 1'b0;
        ill       = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        retire    = 1'b0;
        res       = RES_ALUOUT;
        src_a     = SRCA_PC;
        src_b     = SRCB_RS2;
        alu_op    = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                mv    = 1'b1;
                res   = RES_ALU;
                src_a = SRCA_PC;
                src_b = SRCB_FOUR;
                if (mem_ready) begin
                    irw       = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                if (cls.load || cls.store) state_d = S_MEMADR;
                else if (cls.rtype)        state_d = S_EXECUTER;
                else if (cls.itype)        state_d = S_EXECUTEI;
                else if (cls.branch)       state_d = S_BEQ;
                else if (cls.jal)          state_d = S_JAL;
                else begin
                    ill     = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                src_a = SRCA_RS1;
                src_b = SRCB_IMM;
                if (cls.load)       state_d = S_MEMREAD;
                else if (cls.store) state_d = S_MEMWRITE;
                else                state_d = S_FETCH;
            end
            S_MEMREAD: begin
                mv  = 1'b1;
                adr = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res     = RES_MEM;
                rw      = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                mv  = 1'b1;
                adr = 1'b1;
                if (mem_ready) begin
                    mw      = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_RS2;
                alu_op  = ALU_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                alu_op  = ALU_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rw      = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                src_a     = SRCA_OLDPC;
                src_b     = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_RS2;
                alu_op  = ALU_SUB;
                branch  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Reset is level-gated onto every output so an asynchronous reset kills
    // strobes immediately, not at the next clock edge.
    always_comb begin
        mem_valid     = reset_n & mv;
        Adr_src       = reset_n & adr;
        Mem_write     = reset_n & mw;
        IR_write      = reset_n & irw;
        PC_write      = reset_n & (pc_update | (branch & zero));
        Reg_write     = reset_n & rw;
        illegal_instr = reset_n & ill;
        Result_src    = reset_n ? res     : '0;
        ALU_src_A     = reset_n ? src_a   : '0;
        ALU_src_B     = reset_n ? src_b   : '0;
        ALU_opcode    = reset_n ? alu_op  : '0;
        Imm_src       = reset_n ? imm_src : '0;
    end

    assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed-vector bench for multicycle_ctrl_fsm with a queue-based scoreboard;
// a second instance with CNT_W = 2 exercises counter wrap.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] L_OP = 7'b0000011;
    localparam logic [6:0] S_OP = 7'b0100011;
    localparam logic [6:0] I_OP = 7'b0010011;
    localparam logic [6:0] B_OP = 7'b1100011;
    localparam logic [6:0] J_OP = 7'b1101111;
    localparam logic [6:0] X_OP = 7'b1111111;

    // {mem_valid, Adr_src, Mem_write, IR_write, PC_write, Reg_write,
    //  Result_src, ALU_src_A, ALU_src_B, ALU_opcode, illegal_instr}
    localparam logic [14:0] E_RST   = 15'b0;
    localparam logic [14:0] E_FW    = {1'b1, 5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_FG    = {1'b1, 2'b00, 2'b11, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_DEC   = {6'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
    localparam logic [14:0] E_ILL   = {6'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1};
    localparam logic [14:0] E_MADR  = {6'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
    localparam logic [14:0] E_MACC  = {2'b11, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_MWB   = {5'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_MWR_G = {2'b11, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_EXR   = {6'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
    localparam logic [14:0] E_EXI   = {6'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
    localparam logic [14:0] E_AWB   = {5'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_JAL   = {4'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_BEQ_T = {4'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
    localparam logic [14:0] E_BEQ_N = {6'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};

    logic clk, reset_n, zero, mem_ready;
    logic [6:0] opcode;

    logic mv1, adr1, mw1, irw1, pcw1, rw1, ill1;
    logic [1:0] res1, a1, b1, aop1, imm1;
    logic [31:0] cnt1;

    logic mv2, adr2, mw2, irw2, pcw2, rw2, ill2;
    logic [1:0] res2, a2, b2, aop2, imm2;
    logic [1:0] cnt2;

    multicycle_ctrl_fsm dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_valid(mv1), .Adr_src(adr1), .Mem_write(mw1), .IR_write(irw1), .PC_write(pcw1),
        .Reg_write(rw1), .Result_src(res1), .ALU_src_A(a1), .ALU_src_B(b1),
        .ALU_opcode(aop1), .Imm_src(imm1), .illegal_instr(ill1), .instr_retired(cnt1)
    );

    multicycle_ctrl_fsm #(.CNT_W(2)) dut_w (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_valid(mv2), .Adr_src(adr2), .Mem_write(mw2), .IR_write(irw2), .PC_write(pcw2),
        .Reg_write(rw2), .Result_src(res2), .ALU_src_A(a2), .ALU_src_B(b2),
        .ALU_opcode(aop2), .Imm_src(imm2), .illegal_instr(ill2), .instr_retired(cnt2)
    );

    logic [16:0] act1, act2;
    assign act1 = {mv1, adr1, mw1, irw1, pcw1, rw1, res1, a1, b1, aop1, ill1, imm1};
    assign act2 = {mv2, adr2, mw2, irw2, pcw2, rw2, res2, a2, b2, aop2, ill2, imm2};

    typedef struct {
        logic [14:0] ctl;
        logic [1:0]  imm;
        int unsigned cnt;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int unsigned total = 0;
    int unsigned bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            total++;
            if (act1 !== {e.ctl, e.imm}) begin
                bad++;
                $display("FAIL %s ctl: got %h want %h", e.tag, act1, {e.ctl, e.imm});
            end
            total++;
            if (act2 !== {e.ctl, e.imm}) begin
                bad++;
                $display("FAIL %s ctl_w2: got %h want %h", e.tag, act2, {e.ctl, e.imm});
            end
            total++;
            if (cnt1 !== e.cnt) begin
                bad++;
                $display("FAIL %s retired: got %0d want %0d", e.tag, cnt1, e.cnt);
            end
            total++;
            if (cnt2 !== 2'(e.cnt)) begin
                bad++;
                $display("FAIL %s retired_w2: got %0d want %0d", e.tag, cnt2, 2'(e.cnt));
            end
        end
    end

    task automatic push_exp(input logic [14:0] ctl, input logic [1:0] imm,
                            input int unsigned cnt, input string tag);
        exp_t x;
        x.ctl = ctl;
        x.imm = imm;
        x.cnt = cnt;
        x.tag = tag;
        sbq.push_back(x);
    endtask

    task automatic cyc(input logic rn, input logic mr, input logic z, input logic [6:0] op,
                       input logic [14:0] ctl, input logic [1:0] imm,
                       input int unsigned cnt, input string tag);
        @(posedge clk);
        #1;
        reset_n   = rn;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        push_exp(ctl, imm, cnt, tag);
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = R_OP;

        cyc(0, 0, 0, R_OP, E_RST, 2'b00, 0, "rst0");
        cyc(0, 1, 1, R_OP, E_RST, 2'b00, 0, "rst1");

        cyc(1, 1, 0, R_OP, E_FG,  2'b00, 0, "r_fetch");
        cyc(1, 1, 0, R_OP, E_DEC, 2'b00, 0, "r_dec");
        cyc(1, 1, 0, R_OP, E_EXR, 2'b00, 0, "r_exe");
        cyc(1, 1, 0, R_OP, E_AWB, 2'b00, 0, "r_wb");

        cyc(1, 0, 0, L_OP, E_FW,   2'b00, 1, "lw_fwait0");
        cyc(1, 0, 0, L_OP, E_FW,   2'b00, 1, "lw_fwait1");
        cyc(1, 1, 0, L_OP, E_FG,   2'b00, 1, "lw_fetch");
        cyc(1, 0, 0, L_OP, E_DEC,  2'b00, 1, "lw_dec");
        cyc(1, 0, 0, L_OP, E_MADR, 2'b00, 1, "lw_adr");
        cyc(1, 0, 0, L_OP, E_MACC, 2'b00, 1, "lw_rwait0");
        cyc(1, 0, 0, L_OP, E_MACC, 2'b00, 1, "lw_rwait1");
        cyc(1, 0, 0, L_OP, E_MACC, 2'b00, 1, "lw_rwait2");
        cyc(1, 1, 0, L_OP, E_MACC, 2'b00, 1, "lw_read");
        cyc(1, 1, 0, L_OP, E_MWB,  2'b00, 1, "lw_wb");

        cyc(1, 1, 1, B_OP, E_FG,    2'b10, 2, "beqt_fetch");
        cyc(1, 1, 1, B_OP, E_DEC,   2'b10, 2, "beqt_dec");
        cyc(1, 1, 1, B_OP, E_BEQ_T, 2'b10, 2, "beqt_beq");
        cyc(1, 1, 0, B_OP, E_FG,    2'b10, 3, "beqn_fetch");
        cyc(1, 1, 0, B_OP, E_DEC,   2'b10, 3, "beqn_dec");
        cyc(1, 1, 0, B_OP, E_BEQ_N, 2'b10, 3, "beqn_beq");

        cyc(1, 1, 0, S_OP, E_FG,    2'b01, 4, "sw_fetch");
        cyc(1, 1, 0, S_OP, E_DEC,   2'b01, 4, "sw_dec");
        cyc(1, 1, 0, S_OP, E_MADR,  2'b01, 4, "sw_adr");
        cyc(1, 0, 0, S_OP, E_MACC,  2'b01, 4, "sw_wwait");
        cyc(1, 1, 0, S_OP, E_MWR_G, 2'b01, 4, "sw_write");

        cyc(1, 1, 0, X_OP, E_FG,  2'b00, 5, "ill_fetch");
        cyc(1, 1, 0, X_OP, E_ILL, 2'b00, 5, "ill_dec");

        cyc(1, 1, 0, I_OP, E_FG,  2'b00, 5, "i_fetch");
        cyc(1, 1, 0, I_OP, E_DEC, 2'b00, 5, "i_dec");
        cyc(1, 1, 0, I_OP, E_EXI, 2'b00, 5, "i_exe");
        cyc(1, 1, 0, I_OP, E_AWB, 2'b00, 5, "i_wb");

        cyc(1, 1, 0, J_OP, E_FG,  2'b11, 6, "jal_fetch");
        cyc(1, 1, 0, J_OP, E_DEC, 2'b11, 6, "jal_dec");
        cyc(1, 1, 0, J_OP, E_JAL, 2'b11, 6, "jal_jal");
        cyc(1, 1, 0, J_OP, E_AWB, 2'b11, 6, "jal_wb");

        cyc(1, 1, 0, S_OP, E_FG,   2'b01, 7, "swab_fetch");
        cyc(1, 1, 0, S_OP, E_DEC,  2'b01, 7, "swab_dec");
        cyc(1, 1, 0, S_OP, E_MADR, 2'b01, 7, "swab_adr");
        cyc(1, 0, 0, S_OP, E_MACC, 2'b01, 7, "swab_wwait");

        // Reset drops mid-cycle while MEMWRITE sees mem_ready = 1.
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        push_exp(E_RST, 2'b00, 0, "swab_reset");

        cyc(1, 1, 0, R_OP, E_FG,  2'b00, 0, "post_fetch");
        cyc(1, 1, 0, R_OP, E_DEC, 2'b00, 0, "post_dec");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
